// File: rtl/seven_seg_ctrl_if.sv
// CPU I/O bus bundle for the seven-segment display controller.
// The bus is a simple req/ack handshake with a one-cycle acknowledge.
interface seven_seg_ctrl_if;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_re,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_re,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/seven_seg_ctrl.sv
// Bus front end for the four-digit seven-segment display: DATA/CTRL/STATUS
// registers behind a req/ack handshake, plus the digit scan and half-toggle timers.
module seven_seg_ctrl #(
    parameter int SCAN_DIV = 2,
    parameter int HALF_DIV = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seven_seg_ctrl_if.slave      bus,
    output logic [31:0]          display_code,
    output logic [1:0]           sw,
    output logic [1:0]           scanning
);

    typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

    state_t                state;
    state_t                state_next;
    logic                  access;
    logic                  ack_c;
    logic                  do_write;
    logic                  do_read;
    logic [31:0]           read_value;
    logic [31:0]           data_reg;
    logic [2:0]            ctrl_reg;
    logic [31:0]           rdata_reg;
    logic [SCAN_DIV+1:0]   scan_cnt;
    logic [HALF_DIV-1:0]   half_cnt;
    logic                  half_tgl;
    logic [15:0]           frame_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // HOLD swallows a request that is still asserted after its ack, so one
    // held request is never serviced twice.
    always_comb begin
        state_next = state;
        access     = 1'b0;
        ack_c      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.bus_we || bus.bus_re) begin
                    access     = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                ack_c      = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (!(bus.bus_we || bus.bus_re)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign do_write = access && bus.bus_we;
    assign do_read  = access && bus.bus_re && !bus.bus_we;

    always_comb begin
        read_value = 32'h0;
        case (bus.bus_addr)
            2'd0:    read_value = data_reg;
            2'd1:    read_value = {29'h0, ctrl_reg};
            2'd2:    read_value = {14'h0, scanning, frame_cnt};
            default: read_value = 32'h0;
        endcase
    end

    // A simultaneous read+write counts as a write and returns zero data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_reg  <= 32'h0;
            ctrl_reg  <= 3'h0;
            rdata_reg <= 32'h0;
        end else begin
            if (do_write && bus.bus_addr == 2'd0) data_reg <= bus.bus_wdata;
            if (do_write && bus.bus_addr == 2'd1) ctrl_reg <= bus.bus_wdata[2:0];
            if (do_read)
                rdata_reg <= read_value;
            else
                rdata_reg <= 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            half_cnt  <= '0;
            half_tgl  <= 1'b0;
            frame_cnt <= 16'h0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            half_cnt <= half_cnt + 1'b1;
            if (&scan_cnt)                  frame_cnt <= frame_cnt + 1'b1;
            if (ctrl_reg[2] && (&half_cnt)) half_tgl  <= ~half_tgl;
        end
    end

    assign scanning      = scan_cnt[SCAN_DIV+1:SCAN_DIV];
    assign display_code  = data_reg;
    assign sw            = {(ctrl_reg[2] ? half_tgl : ctrl_reg[1]), ctrl_reg[0]};
    assign bus.bus_ack   = ack_c;
    assign bus.bus_rdata = rdata_reg;

endmodule

// File: tb/tb_seven_seg_ctrl.sv
// Directed bench for seven_seg_ctrl: handshake timing, register map,
// scan/frame/half-toggle timers and reset in the middle of a transaction.
module tb_seven_seg_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] display_code;
    logic [1:0]  sw;
    logic [1:0]  scanning;
    int          checks;
    int          failures;
    int          cyc;

    seven_seg_ctrl_if bif();

    seven_seg_ctrl #(.SCAN_DIV(2), .HALF_DIV(6)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bif.slave),
        .display_code (display_code),
        .sw           (sw),
        .scanning     (scanning)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; matches every free-running counter's phase.
    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete transaction; returns captured read data and the edge index of the ack.
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] wdata,
                                 input logic we, input logic re,
                                 output logic [31:0] rdata, output int ack_cyc);
        int waited;
        @(negedge clk);
        bif.bus_addr  = addr;
        bif.bus_wdata = wdata;
        bif.bus_we    = we;
        bif.bus_re    = re;
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!bif.bus_ack && waited < 8);
        checkOutput("ack_latency", waited, 1);
        rdata   = bif.bus_rdata;
        ack_cyc = cyc;
        bif.bus_we = 1'b0;
        bif.bus_re = 1'b0;
        @(posedge clk); #1;
        checkOutput("ack_one_cycle", {31'h0, bif.bus_ack}, 0);
        checkOutput("rdata_clear", bif.bus_rdata, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd;
        int          ack_c;
        int          w_cyc;
        int          acks;
        int          cap_cyc;
        logic [31:0] cap;

        checks = 0;
        failures = 0;
        bif.bus_addr = 2'd0;
        bif.bus_wdata = 32'h0;
        bif.bus_we = 1'b0;
        bif.bus_re = 1'b0;
        rst_n = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_display", display_code, 0);
        checkOutput("rst_sw", {30'h0, sw}, 0);
        checkOutput("rst_scanning", {30'h0, scanning}, 0);
        checkOutput("rst_ack", {31'h0, bif.bus_ack}, 0);
        checkOutput("rst_rdata", bif.bus_rdata, 0);
        rst_n = 1'b1;

        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            if (k == 3 || k == 4 || k == 8 || k == 12 || k == 16)
                checkOutput($sformatf("scan_k%0d", k), {30'h0, scanning}, (k >> 2) & 3);
        end

        applyStimulus(2'd0, 32'h1234ABCD, 1'b1, 1'b0, rd, ack_c);
        checkOutput("data_display", display_code, 32'h1234ABCD);
        applyStimulus(2'd0, 32'h0, 1'b0, 1'b1, rd, ack_c);
        checkOutput("data_read", rd, 32'h1234ABCD);

        applyStimulus(2'd1, 32'hFFFF_FFFB, 1'b1, 1'b0, rd, ack_c);
        checkOutput("ctrl_sw11", {30'h0, sw}, 2'b11);
        applyStimulus(2'd1, 32'h0, 1'b0, 1'b1, rd, ack_c);
        checkOutput("ctrl_read", rd, 32'h3);

        // STATUS read with the request held for ten cycles: one ack only.
        @(negedge clk);
        bif.bus_addr = 2'd2;
        bif.bus_re   = 1'b1;
        acks = 0;
        cap = 32'h0;
        cap_cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bif.bus_ack) begin
                acks++;
                cap = bif.bus_rdata;
                cap_cyc = cyc;
            end
        end
        bif.bus_re = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("held_read_acks", acks, 1);
        checkOutput("status_frame", {16'h0, cap[15:0]}, ((cap_cyc - 1) >> 4) & 16'hFFFF);
        checkOutput("status_scan", {30'h0, cap[17:16]}, ((cap_cyc - 1) >> 2) & 3);
        checkOutput("status_upper", {18'h0, cap[31:18]}, 0);

        // Automatic half toggle: flips on every edge whose index is a multiple of 64.
        applyStimulus(2'd1, 32'h4, 1'b1, 1'b0, rd, w_cyc);
        checkOutput("auto_sw0", {31'h0, sw[0]}, 0);
        for (int i = 0; i < 140; i++) begin
            @(posedge clk); #1;
            if ((cyc % 64) == 0 || (cyc % 64) == 63)
                checkOutput($sformatf("auto_sw1_c%0d", cyc), {31'h0, sw[1]},
                            ((cyc >> 6) - (w_cyc >> 6)) & 1);
        end

        applyStimulus(2'd0, 32'hDEADBEEF, 1'b1, 1'b1, rd, ack_c);
        checkOutput("rw_rdata_zero", rd, 0);
        checkOutput("rw_display", display_code, 32'hDEADBEEF);

        applyStimulus(2'd2, 32'hFFFF_FFFF, 1'b1, 1'b0, rd, ack_c);
        applyStimulus(2'd2, 32'h0, 1'b0, 1'b1, rd, ack_c);
        checkOutput("status_ro_upper", {18'h0, rd[31:18]}, 0);
        checkOutput("status_ro_frame", {16'h0, rd[15:0]}, ((ack_c - 1) >> 4) & 16'hFFFF);
        applyStimulus(2'd3, 32'hA5A5_A5A5, 1'b1, 1'b0, rd, ack_c);
        checkOutput("addr3_write_ignored", display_code, 32'hDEADBEEF);
        applyStimulus(2'd3, 32'h0, 1'b0, 1'b1, rd, ack_c);
        checkOutput("addr3_read", rd, 0);

        // Reset lands during the ack cycle; the still-held write is redone afterwards.
        @(negedge clk);
        bif.bus_addr  = 2'd0;
        bif.bus_wdata = 32'h55;
        bif.bus_we    = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid_first_ack", {31'h0, bif.bus_ack}, 1);
        checkOutput("mid_first_data", display_code, 32'h55);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("mid_rst_display", display_code, 0);
        checkOutput("mid_rst_ack", {31'h0, bif.bus_ack}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid_reack", {31'h0, bif.bus_ack}, 1);
        checkOutput("mid_redisplay", display_code, 32'h55);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bif.bus_ack) acks++;
        end
        bif.bus_we = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bif.bus_ack) acks++;
        end
        checkOutput("mid_extra_acks", acks, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
